// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-synchronous shadow load, dead time and 16-level PWM.
// Optional build macro LEADING_ZERO_BLANK_EN adds leading-zero suppression computed at shadow capture.
module seg_scan_driver #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     sel_out,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = CW + 5;
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]            cnt_reg;
    logic [IW-1:0]            idx_reg;
    logic [DIGITS-1:0][3:0]   shadow_data_reg;
    logic [DIGITS-1:0]        shadow_dp_reg;
    logic [DIGITS-1:0]        shadow_blank_reg;
    logic                     shadow_valid_reg;
    logic                     load_pending_reg;

    logic                     cnt_last;
    logic                     frame_wrap;
    logic                     capture;
    logic [PW-1:0]            pwm_lhs;
    logic [PW-1:0]            pwm_rhs;
    logic                     in_window;
    logic [DIGITS-1:0]        blank_eff;
    logic                     show;
    logic [DIGITS-1:0]        onehot;
    logic [7:0]               pattern;
    logic [7:0]               seg_next;
    logic [DIGITS-1:0]        sel_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign cnt_last   = (cnt_reg == CW'(SCAN_DIV - 1));
    assign frame_wrap = cnt_last && (idx_reg == IW'(DIGITS - 1));
    assign capture    = frame_wrap && (load_pending_reg || load);

    // Compare cnt*16 against (brightness+1)*SCAN_DIV in a width that cannot overflow.
    assign pwm_lhs   = PW'({cnt_reg, 4'b0000});
    assign pwm_rhs   = PW'({1'b0, brightness} + 5'd1) * PW'(SCAN_DIV);
    assign in_window = (cnt_reg >= CW'(BLANK_CYCLES)) && (pwm_lhs < pwm_rhs);

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] lz_mask_next;
    logic [DIGITS-1:0] lz_mask_reg;
    logic              zero_run;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
        assign digit_zero[gi] = (data_in[4*gi +: 4] == 4'h0) && !dp_in[gi];
    end

    // Walk down from the top digit; suppression stops at the first significant digit.
    always_comb begin
        zero_run     = 1'b1;
        lz_mask_next = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run        = zero_run & digit_zero[i];
            lz_mask_next[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lz_mask_reg <= '0;
        end else if (capture) begin
            lz_mask_reg <= lz_mask_next;
        end
    end

    assign blank_eff = shadow_blank_reg | lz_mask_reg;
`else
    assign blank_eff = shadow_blank_reg;
`endif

    // The display stays dark until the first shadow capture after reset.
    assign show     = shadow_valid_reg && in_window && !blank_eff[idx_reg];
    assign onehot   = DIGITS'(1) << idx_reg;
    assign pattern  = {shadow_dp_reg[idx_reg], hex_to_seg(shadow_data_reg[idx_reg])};
    assign seg_next = show ? ((SEG_ACTIVE_LOW != 0) ? ~pattern : pattern) : SEG_OFF;
    assign sel_next = show ? ((SEL_ACTIVE_LOW != 0) ? ~onehot : onehot) : SEL_OFF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg          <= '0;
            idx_reg          <= '0;
            shadow_data_reg  <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            shadow_valid_reg <= 1'b0;
            load_pending_reg <= 1'b0;
            seg_out          <= SEG_OFF;
            sel_out          <= SEL_OFF;
            frame_done       <= 1'b0;
        end else begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
            if (cnt_last) begin
                idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
            if (capture) begin
                shadow_data_reg  <= data_in;
                shadow_dp_reg    <= dp_in;
                shadow_blank_reg <= blank_in;
                shadow_valid_reg <= 1'b1;
                load_pending_reg <= 1'b0;
            end else if (load) begin
                load_pending_reg <= 1'b1;
            end
            frame_done <= frame_wrap;
            seg_out    <= seg_next;
            sel_out    <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 16-cycle slots, 2 dead cycles, active-low pins).
// Expectations for the suppression scenario follow the LEADING_ZERO_BLANK_EN build macro.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  brightness;
    logic [7:0]  seg_out;
    logic [3:0]  sel_out;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    int act_cnt   [4];
    int seg_val   [4];
    int first_pos [4];
    int last_pos  [4];
    int bad;
    int fd_hits;
    int fd_at;
    int dark_n;
    int dark_bad;

    seg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(16), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .brightness(brightness),
        .seg_out(seg_out), .sel_out(sel_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Samples the 64 output cycles of the frame that starts at the current frame_done.
    task automatic run_frame(input int load_at);
        logic [3:0] oh;
        int found;
        for (int d = 0; d < 4; d++) begin
            act_cnt[d] = 0; seg_val[d] = 'hFF; first_pos[d] = -1; last_pos[d] = -1;
        end
        bad = 0; fd_hits = 0; fd_at = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (frame_done) begin fd_hits++; fd_at = k; end
            if (sel_out == 4'hF) begin
                if (seg_out != 8'hFF) bad++;
            end else begin
                found = -1;
                for (int d = 0; d < 4; d++) begin
                    oh = 4'b0001 << d;
                    if (sel_out == ~oh) found = d;
                end
                if (found < 0 || found != (k - 1) / 16) begin
                    bad++;
                end else begin
                    if (act_cnt[found] > 0 && seg_val[found] != int'(seg_out)) bad++;
                    act_cnt[found]++;
                    seg_val[found] = seg_out;
                    if (first_pos[found] < 0) first_pos[found] = (k - 1) % 16;
                    last_pos[found] = (k - 1) % 16;
                end
            end
            load = (k == load_at);
        end
        load = 1'b0;
    endtask

    // From reset release up to the first frame_done; output must stay dark throughout.
    task automatic dark_frame(input int load_at);
        dark_n = 0; dark_bad = 0;
        while (dark_n < 200) begin
            @(negedge clk);
            dark_n++;
            if (frame_done) break;
            if (sel_out != 4'hF || seg_out != 8'hFF) dark_bad++;
            load = (dark_n == load_at);
        end
        load = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [3:0][7:0] e_seg, input logic [3:0][7:0] e_cnt);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_seg%0d", tag, d), seg_val[d], int'(e_seg[d]));
            chk($sformatf("%s_cnt%0d", tag, d), act_cnt[d], int'(e_cnt[d]));
        end
        chk({tag, "_bad"}, bad, 0);
        chk({tag, "_fd_hits"}, fd_hits, 1);
        chk({tag, "_fd_at"}, fd_at, 64);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; data_in = 16'h0000; dp_in = 4'h0; blank_in = 4'h0;
        brightness = 4'd15;
        repeat (3) @(negedge clk);
        chk("reset_seg", seg_out, 'hFF);
        chk("reset_sel", sel_out, 'hF);
        chk("reset_fd", frame_done, 0);

        data_in = 16'h1234;
        rst = 1'b1;
        dark_frame(3);
        chk("first_frame_len", dark_n, 64);
        chk("first_frame_dark", dark_bad, 0);

        run_frame(-1);
        check_frame("f1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'd14, 8'd14, 8'd14, 8'd14});

        data_in = 16'h5678;
        run_frame(-1);
        check_frame("tear_noload", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'd14, 8'd14, 8'd14, 8'd14});
        run_frame(30);
        check_frame("tear_loadframe", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'd14, 8'd14, 8'd14, 8'd14});
        run_frame(-1);
        check_frame("f5678", {8'h92, 8'h82, 8'hF8, 8'h80}, {8'd14, 8'd14, 8'd14, 8'd14});

        brightness = 4'd7;
        run_frame(-1);
        check_frame("bright7", {8'h92, 8'h82, 8'hF8, 8'h80}, {8'd6, 8'd6, 8'd6, 8'd6});
        chk("bright7_first", first_pos[0], 2);
        chk("bright7_last", last_pos[0], 7);
        brightness = 4'd0;
        run_frame(-1);
        check_frame("bright0", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'd0, 8'd0, 8'd0, 8'd0});

        brightness = 4'd15;
        dp_in = 4'b0010; blank_in = 4'b1000;
        run_frame(10);
        check_frame("dp_loadframe", {8'h92, 8'h82, 8'hF8, 8'h80}, {8'd14, 8'd14, 8'd14, 8'd14});
        run_frame(-1);
        check_frame("dp_blank", {8'hFF, 8'h82, 8'h78, 8'h80}, {8'd0, 8'd14, 8'd14, 8'd14});

        dp_in = 4'b0000; blank_in = 4'b0000; data_in = 16'h0050;
        run_frame(10);
        check_frame("lz_loadframe", {8'hFF, 8'h82, 8'h78, 8'h80}, {8'd0, 8'd14, 8'd14, 8'd14});
        run_frame(-1);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("lz_0050", {8'hFF, 8'hFF, 8'h92, 8'hC0}, {8'd0, 8'd0, 8'd14, 8'd14});
`else
        check_frame("lz_0050", {8'hC0, 8'hC0, 8'h92, 8'hC0}, {8'd14, 8'd14, 8'd14, 8'd14});
`endif
        data_in = 16'h0000;
        run_frame(10);
        run_frame(-1);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("lz_0000", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {8'd0, 8'd0, 8'd0, 8'd14});
`else
        check_frame("lz_0000", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {8'd14, 8'd14, 8'd14, 8'd14});
`endif

        // Async reset in the middle of digit 2's lit window.
        data_in = 16'h1234;
        run_frame(10);
        repeat (38) @(negedge clk);
        chk("pre_reset_sel", sel_out, 'hB);
        chk("pre_reset_seg", seg_out, 'hA4);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_seg", seg_out, 'hFF);
        chk("async_reset_sel", sel_out, 'hF);
        chk("async_reset_fd", frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        dark_frame(-1);
        chk("rerun_frame_len", dark_n, 64);
        chk("rerun_frame_dark", dark_bad, 0);
        run_frame(-1);
        check_frame("shadow_cleared", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'd0, 8'd0, 8'd0, 8'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
